// File: rtl/status_register_unit.sv
// NZCV flag producer in EXE: derives flags from the ALU result and commits them to the
// status register when a valid S-suffixed instruction retires; also forwards and flags hazards.
module status_register_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic             s_in,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_carry,
    input  logic             freeze,
    input  logic             flush,
    output logic [3:0]       sr_out,
    output logic [3:0]       sr_fwd,
    output logic             sr_pending
);

    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;

    logic [3:0] sr_q;
    logic [3:0] sr_d;
    logic       is_add;
    logic       is_sub;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;
    logic       update;

    function automatic logic ovf_add(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    always_comb begin
        is_add = (exe_cmd == CMD_ADD) || (exe_cmd == CMD_ADC);
        is_sub = (exe_cmd == CMD_SUB) || (exe_cmd == CMD_SBC);
    end

    // Logic-class ops leave C and V at their committed values (no shifter carry).
    always_comb begin
        n_flag = alu_res[WIDTH-1];
        z_flag = (alu_res == '0);
        c_flag = sr_q[1];
        v_flag = sr_q[0];
        if (is_add) begin
            c_flag = alu_carry;
            v_flag = ovf_add(op_a[WIDTH-1], op_b[WIDTH-1], alu_res[WIDTH-1]);
        end else if (is_sub) begin
            c_flag = alu_carry;
            v_flag = ovf_sub(op_a[WIDTH-1], op_b[WIDTH-1], alu_res[WIDTH-1]);
        end
    end

    always_comb begin
        update = valid_in & s_in & ~flush & ~freeze;
        sr_d   = update ? {n_flag, z_flag, c_flag, v_flag} : sr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= 4'b0000;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Pending stays high through freeze so ID keeps stalling until the commit lands.
    assign sr_out     = sr_q;
    assign sr_fwd     = sr_d;
    assign sr_pending = valid_in & s_in & ~flush;

endmodule

// File: tb/tb_status_register_unit.sv
// Self-checking bench for status_register_unit: directed scenarios plus randomized traffic
// compared against a flag model derived from signed arithmetic.
module tb_status_register_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         s_in;
    logic [3:0]   exe_cmd;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic         freeze;
    logic         flush;
    logic [3:0]   sr_out;
    logic [3:0]   sr_fwd;
    logic         sr_pending;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_sr;

    always #5 clk = ~clk;

    status_register_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .s_in(s_in), .exe_cmd(exe_cmd),
        .op_a(op_a), .op_b(op_b), .alu_res(alu_res), .alu_carry(alu_carry),
        .freeze(freeze), .flush(flush), .sr_out(sr_out), .sr_fwd(sr_fwd),
        .sr_pending(sr_pending)
    );

    // Reference: flags from signed interpretation of operands/result.
    function automatic logic [3:0] ref_flags(input logic [3:0] cmd, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] r,
                                             input logic c, input logic [3:0] cur);
        bit a_neg = ($signed(a) < 0);
        bit b_neg = ($signed(b) < 0);
        bit r_neg = ($signed(r) < 0);
        bit n = r_neg;
        bit z = (r == 0);
        bit cf = cur[1];
        bit vf = cur[0];
        if (cmd inside {4'd2, 4'd3}) begin
            cf = c;
            vf = (a_neg == b_neg) && (r_neg != a_neg);
        end else if (cmd inside {4'd4, 4'd5}) begin
            cf = c;
            vf = (a_neg != b_neg) && (r_neg != a_neg);
        end
        return {n, z, cf, vf};
    endfunction

    function automatic logic ref_update();
        return valid_in && s_in && !flush && !freeze;
    endfunction

    function automatic logic [3:0] ref_fwd();
        return ref_update() ? ref_flags(exe_cmd, op_a, op_b, alu_res, alu_carry, exp_sr) : exp_sr;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [3:0] cmd,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                         input logic c, input logic frz, input logic fl, input logic rs);
        valid_in = v; s_in = s; exe_cmd = cmd; op_a = a; op_b = b; alu_res = r;
        alu_carry = c; freeze = frz; flush = fl; rst = rs;
        #1;
    endtask

    task automatic tick();
        logic [3:0] nxt;
        if (rst) nxt = 4'b0000;
        else     nxt = ref_fwd();
        @(posedge clk);
        #1;
        exp_sr = nxt;
    endtask

    task automatic test_reset();
        drive(1, 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (sr_pending !== 1'b1) begin
                errors++; $display("FAIL reset_pending got=%b want=1", sr_pending);
            end
            tick();
            checks++;
            if (sr_out !== 4'b0000) begin
                errors++; $display("FAIL reset_sr cycle%0d got=%b want=0000", i, sr_out);
            end
        end
        checks++;
        if (sr_fwd !== 4'b1001) begin
            errors++; $display("FAIL reset_fwd got=%b want=1001", sr_fwd);
        end
        drive(0, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 1);
        checks++;
        if (sr_pending !== 1'b0) begin
            errors++; $display("FAIL reset_pending_idle got=%b want=0", sr_pending);
        end
        tick();
    endtask

    task automatic test_add_overflow();
        drive(1, 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0);
        checks++;
        if (sr_fwd !== 4'b1001) begin
            errors++; $display("FAIL add_fwd got=%b want=1001", sr_fwd);
        end
        tick();
        checks++;
        if (sr_out !== 4'b1001) begin
            errors++; $display("FAIL add_sr got=%b want=1001", sr_out);
        end
    endtask

    task automatic test_sub_then_logic();
        drive(1, 1, 4'b0100, 32'd5, 32'd5, 32'd0, 1, 0, 0, 0);
        tick();
        checks++;
        if (sr_out !== 4'b0110) begin
            errors++; $display("FAIL sub_sr got=%b want=0110", sr_out);
        end
        drive(1, 1, 4'b0110, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'd0, 0, 0, 0, 0);
        tick();
        checks++;
        if (sr_out !== 4'b0110) begin
            errors++; $display("FAIL and_retain_sr got=%b want=0110", sr_out);
        end
    endtask

    task automatic test_freeze();
        drive(1, 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4'b0010, 32'd0, 32'd0, 32'd0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sr_pending !== 1'b1 || sr_fwd !== 4'b1001) begin
                errors++;
                $display("FAIL freeze_comb cycle%0d got pend=%b fwd=%b want pend=1 fwd=1001",
                         i, sr_pending, sr_fwd);
            end
            tick();
            checks++;
            if (sr_out !== 4'b1001) begin
                errors++; $display("FAIL freeze_hold cycle%0d got=%b want=1001", i, sr_out);
            end
        end
        freeze = 1'b0;
        #1;
        tick();
        checks++;
        if (sr_out !== 4'b0110) begin
            errors++; $display("FAIL freeze_release got=%b want=0110", sr_out);
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 4'b0100, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 1, 0);
        checks++;
        if (sr_pending !== 1'b0 || sr_fwd !== 4'b0110) begin
            errors++;
            $display("FAIL flush_comb got pend=%b fwd=%b want pend=0 fwd=0110", sr_pending, sr_fwd);
        end
        tick();
        checks++;
        if (sr_out !== 4'b0110) begin
            errors++; $display("FAIL flush_hold got=%b want=0110", sr_out);
        end
        drive(1, 0, 4'b0100, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0);
        tick();
        checks++;
        if (sr_out !== 4'b0110) begin
            errors++; $display("FAIL nos_hold got=%b want=0110", sr_out);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 4'b0101, 32'd0, 32'd1, 32'hFFFFFFFF, 0, 0, 0, 0);
        checks++;
        if (sr_fwd !== 4'b1000) begin
            errors++; $display("FAIL b2b_fwd1 got=%b want=1000", sr_fwd);
        end
        tick();
        checks++;
        if (sr_out !== 4'b1000) begin
            errors++; $display("FAIL b2b_sr1 got=%b want=1000", sr_out);
        end
        drive(1, 1, 4'b0111, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'd0, 1, 0, 0, 0);
        checks++;
        if (sr_fwd !== 4'b0100) begin
            errors++; $display("FAIL b2b_fwd2 got=%b want=0100", sr_fwd);
        end
        tick();
        checks++;
        if (sr_out !== 4'b0100) begin
            errors++; $display("FAIL b2b_sr2 got=%b want=0100", sr_out);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 1, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 0);
        tick();
        drive(1, 1, 4'b0010, 32'd0, 32'd0, 32'd0, 1, 1, 0, 1);
        tick();
        checks++;
        if (sr_out !== 4'b0000) begin
            errors++; $display("FAIL rst_stall got=%b want=0000", sr_out);
        end
    endtask

    task automatic test_random();
        logic [3:0] cmds [10] = '{4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100,
                                  4'b0101, 4'b0110, 4'b1000, 4'b0111, 4'b1111};
        logic [W-1:0] a, b, r;
        logic [3:0] cmd;
        for (int i = 0; i < 400; i++) begin
            cmd = cmds[$urandom_range(0, 9)];
            a = $urandom();
            b = $urandom();
            if ($urandom_range(0, 3) == 0) b = a;
            r = (cmd inside {4'd4, 4'd5}) ? a - b : a + b;
            if ($urandom_range(0, 5) == 0) r = '0;
            drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, cmd, a, b, r,
                  1'($urandom()), $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 30) == 0);
            checks++;
            if (sr_pending !== (valid_in && s_in && !flush)) begin
                errors++; $display("FAIL rnd_pending it%0d got=%b", i, sr_pending);
            end
            checks++;
            if (sr_fwd !== ref_fwd()) begin
                errors++; $display("FAIL rnd_fwd it%0d got=%b want=%b", i, sr_fwd, ref_fwd());
            end
            tick();
            checks++;
            if (sr_out !== exp_sr) begin
                errors++; $display("FAIL rnd_sr it%0d got=%b want=%b", i, sr_out, exp_sr);
            end
        end
    endtask

    initial begin
        exp_sr = 4'b0000;
        drive(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_add_overflow();
        test_sub_then_logic();
        test_freeze();
        test_flush();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
